// File: rtl/keypad_pkg.sv
// Shared types, key codes and small decode helpers for the matrix keypad
// scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] KEY_CLR    = 4'hE;
  localparam logic [3:0] KEY_ENT    = 4'hF;
  localparam logic [3:0] ROWS_RESET = 4'b1110;

  // One-cold pattern with bit idx low; used for row drives and column matching.
  function automatic logic [3:0] one_cold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // True when exactly one of the four active-low lines is asserted.
  function automatic logic is_single(input logic [3:0] lines);
    case (lines)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] lines);
    case (lines)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running prescaler: one-cycle tick every SCAN_DIV clocks, which paces
// both the row scan and the debounce sampling.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick = (cnt_reg == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner: scans rows, debounces presses and releases,
// and shifts accepted hex digits into an operand with CLR/ENT handling.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [3:0]        Cols,
  output logic [3:0]        Rows,
  output logic [DATA_W-1:0] Data_output,
  output logic              Enter_pulse,
  output logic              Key_valid,
  output logic [3:0]        Key_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic tick;

  keypad_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick_gen (
    .clk  (Clk),
    .reset(Reset),
    .tick (tick)
  );

  // Two-flop synchronizer per column; idle level is high (pulled up).
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      always_ff @(posedge Clk) begin
        if (!Reset) begin
          sync1_reg[gi] <= 1'b1;
          sync2_reg[gi] <= 1'b1;
        end else begin
          sync1_reg[gi] <= Cols[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  state_t            state_reg,   state_next;
  logic [1:0]        row_reg,     row_next;
  logic [1:0]        col_reg,     col_next;
  logic [CNT_W-1:0]  match_reg,   match_next;
  logic [CNT_W-1:0]  release_reg, release_next;
  logic [3:0]        rows_reg,    rows_next;
  logic [DATA_W-1:0] data_reg,    data_next;
  logic [3:0]        code_reg,    code_next;
  logic              valid_reg,   valid_next;
  logic              enter_reg,   enter_next;

  logic [3:0]        sample;
  logic [3:0]        accept_code;
  logic [DATA_W-1:0] shifted;
  logic              accept;

  assign sample      = sync2_reg;
  assign accept_code = {row_reg, col_reg};

  generate
    if (DATA_W > 4) begin : g_shift
      assign shifted = {data_reg[DATA_W-5:0], accept_code};
    end else begin : g_narrow
      assign shifted = accept_code;
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    match_next   = match_reg;
    release_next = release_reg;
    accept       = 1'b0;

    if (tick) begin
      case (state_reg)
        SCAN: begin
          if (is_single(sample)) begin
            col_next   = col_index(sample);
            match_next = CNT_W'(1);
            state_next = DEBOUNCE;
          end else begin
            row_next = row_reg + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (sample == one_cold(col_reg)) begin
            if (match_reg == CNT_W'(DEBOUNCE_CNT - 1)) begin
              accept       = 1'b1;
              match_next   = '0;
              release_next = '0;
              state_next   = HELD;
            end else begin
              match_next = match_reg + CNT_W'(1);
            end
          end else begin
            match_next = '0;
            row_next   = row_reg + 2'd1;
            state_next = SCAN;
          end
        end
        HELD: begin
          // Any low column, even in another position, restarts the release count.
          if (sample == 4'hF) begin
            if (release_reg == CNT_W'(DEBOUNCE_CNT - 1)) begin
              release_next = '0;
              row_next     = row_reg + 2'd1;
              state_next   = SCAN;
            end else begin
              release_next = release_reg + CNT_W'(1);
            end
          end else begin
            release_next = '0;
          end
        end
        default: begin
          state_next = SCAN;
        end
      endcase
    end
  end

  always_comb begin
    rows_next  = one_cold(row_next);
    data_next  = data_reg;
    code_next  = code_reg;
    valid_next = 1'b0;
    enter_next = 1'b0;

    if (accept) begin
      valid_next = 1'b1;
      code_next  = accept_code;
      if (accept_code == KEY_CLR) begin
        data_next = '0;
      end else if (accept_code == KEY_ENT) begin
        enter_next = 1'b1;
      end else begin
        data_next = shifted;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg   <= SCAN;
      row_reg     <= 2'd0;
      col_reg     <= 2'd0;
      match_reg   <= '0;
      release_reg <= '0;
      rows_reg    <= ROWS_RESET;
      data_reg    <= '0;
      code_reg    <= 4'd0;
      valid_reg   <= 1'b0;
      enter_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      match_reg   <= match_next;
      release_reg <= release_next;
      rows_reg    <= rows_next;
      data_reg    <= data_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      enter_reg   <= enter_next;
    end
  end

  assign Rows        = rows_reg;
  assign Data_output = data_reg;
  assign Key_code    = code_reg;
  assign Key_valid   = valid_reg;
  assign Enter_pulse = enter_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural 4x4 key matrix model.
module tb_keypad_entry;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Cols;
  logic [3:0] Rows;
  logic [7:0] Data_output;
  logic       Enter_pulse;
  logic       Key_valid;
  logic [3:0] Key_code;

  logic [15:0] keys = 16'h0000;  // bit r*4+c closed

  int checks = 0;
  int errors = 0;
  int kv_count = 0;
  int ent_count = 0;
  int ent_solo = 0;
  int kv_double = 0;
  logic [3:0] last_code = 4'h0;
  logic kv_prev = 1'b0;

  keypad_entry #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3),
    .DATA_W      (8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Cols       (Cols),
    .Rows       (Rows),
    .Data_output(Data_output),
    .Enter_pulse(Enter_pulse),
    .Key_valid  (Key_valid),
    .Key_code   (Key_code)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    Cols = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (Rows[r] == 1'b0 && keys[r*4+c]) Cols[c] = 1'b0;
      end
    end
  end

  // Strobe monitor, sampled shortly after each rising edge.
  always @(posedge Clk) begin
    #2;
    if (Key_valid === 1'b1) begin
      kv_count++;
      last_code = Key_code;
      if (kv_prev) kv_double++;
      $display("[%0t] key accepted code=%h data=%h enter=%b", $time, Key_code, Data_output, Enter_pulse);
    end
    kv_prev = (Key_valid === 1'b1);
    if (Enter_pulse === 1'b1) begin
      ent_count++;
      if (Key_valid !== 1'b1) ent_solo++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_rows(input logic [3:0] want, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Rows === want) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: Rows never reached %b (now %b)", name, want, Rows);
    end
  endtask

  task automatic wait_strobe(input int start, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (kv_count != start) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_latency: no Key_valid within 40 cycles, required one", name);
    end
  endtask

  task automatic press_and_release(input int r, input int c, input logic [3:0] exp_code,
                                   input logic [7:0] exp_data, input string name);
    int start;
    start = kv_count;
    keys[r*4+c] = 1'b1;
    wait_strobe(start, name);
    cycles(12);
    keys[r*4+c] = 1'b0;
    cycles(24);
    checks++;
    if (kv_count != start + 1) begin
      errors++;
      $display("FAIL %s_count: %0d strobes, required 1", name, kv_count - start);
    end
    checks++;
    if (last_code !== exp_code) begin
      errors++;
      $display("FAIL %s_code: Key_code=%h, required %h", name, last_code, exp_code);
    end
    checks++;
    if (Data_output !== exp_data) begin
      errors++;
      $display("FAIL %s_data: Data_output=%h, required %h", name, Data_output, exp_data);
    end
  endtask

  task automatic test_reset();
    int bad;
    logic [3:0] exp_rows;
    Reset = 1'b0;
    keys = 16'h0;
    cycles(20);
    checks++;
    if (Rows !== 4'b1110 || Data_output !== 8'h00 || Key_valid !== 1'b0 ||
        Enter_pulse !== 1'b0 || Key_code !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: Rows=%b data=%h kv=%b ent=%b code=%h, required 1110 00 0 0 0",
               Rows, Data_output, Key_valid, Enter_pulse, Key_code);
    end
    Reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge Clk);
      exp_rows = ~(4'b0001 << (((k + 1) / 4) % 4));
      checks++;
      if (Rows !== exp_rows) begin
        errors++;
        $display("FAIL scan_rows: cycle %0d Rows=%b, required %b", k, Rows, exp_rows);
      end
    end
  endtask

  task automatic test_digits();
    press_and_release(2, 1, 4'h9, 8'h09, "digit9");
    press_and_release(0, 3, 4'h3, 8'h93, "digit3");
  endtask

  task automatic test_enter();
    int start_e;
    start_e = ent_count;
    press_and_release(3, 3, 4'hF, 8'h93, "enter");
    checks++;
    if (ent_count != start_e + 1) begin
      errors++;
      $display("FAIL enter_pulse: %0d Enter strobes, required 1", ent_count - start_e);
    end
    checks++;
    if (ent_solo != 0 || kv_double != 0) begin
      errors++;
      $display("FAIL enter_align: solo=%0d double=%0d, required 0 0", ent_solo, kv_double);
    end
    press_and_release(3, 2, 4'hE, 8'h00, "clear");
  endtask

  task automatic test_held();
    int start;
    int bad;
    int n;
    start = kv_count;
    keys[2*4+1] = 1'b1;
    wait_strobe(start, "held");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Rows !== 4'b1011) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held_rows: %0d cycles with Rows!=1011, required 0", bad);
    end
    keys[2*4+1] = 1'b0;
    n = 0;
    while (Rows === 4'b1011 && n < 30) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (n < 11 || n > 14 || Rows !== 4'b0111) begin
      errors++;
      $display("FAIL held_resume: Rows=%b after %0d cycles, required 0111 after 11..14", Rows, n);
    end
    cycles(10);
    checks++;
    if (kv_count != start + 1 || last_code !== 4'h9 || Data_output !== 8'h09) begin
      errors++;
      $display("FAIL held_single: strobes=%0d code=%h data=%h, required 1 9 09",
               kv_count - start, last_code, Data_output);
    end
  endtask

  task automatic test_bounce();
    int start;
    start = kv_count;
    wait_rows(4'b1101, "bounce_sync");
    keys[1*4+2] = 1'b1;
    cycles(4);
    keys[1*4+2] = 1'b0;
    cycles(4);
    checks++;
    if (kv_count != start) begin
      errors++;
      $display("FAIL bounce_early: %0d strobes during bounce, required 0", kv_count - start);
    end
    press_and_release(1, 2, 4'h6, 8'h96, "bounce");
    press_and_release(0, 1, 4'h1, 8'h61, "shift_out");
  endtask

  task automatic test_reset_debounce();
    int start;
    start = kv_count;
    wait_rows(4'b1101, "rst_deb_sync");
    keys[0] = 1'b1;
    cycles(18);
    Reset = 1'b0;
    cycles(2);
    keys[0] = 1'b0;
    checks++;
    if (Rows !== 4'b1110 || Data_output !== 8'h00 || Key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_deb_state: Rows=%b data=%h kv=%b, required 1110 00 0",
               Rows, Data_output, Key_valid);
    end
    cycles(2);
    Reset = 1'b1;
    cycles(40);
    checks++;
    if (kv_count != start) begin
      errors++;
      $display("FAIL rst_deb_strobe: %0d strobes, required 0", kv_count - start);
    end
  endtask

  task automatic test_reset_held();
    int start;
    start = kv_count;
    keys[1*4+1] = 1'b1;
    wait_strobe(start, "rst_held");
    checks++;
    if (Data_output !== 8'h05) begin
      errors++;
      $display("FAIL rst_held_data: Data_output=%h, required 05", Data_output);
    end
    cycles(6);
    Reset = 1'b0;
    cycles(2);
    keys[1*4+1] = 1'b0;
    checks++;
    if (Rows !== 4'b1110 || Data_output !== 8'h00 || Key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_held_state: Rows=%b data=%h kv=%b, required 1110 00 0",
               Rows, Data_output, Key_valid);
    end
    cycles(2);
    Reset = 1'b1;
    cycles(40);
    checks++;
    if (kv_count != start + 1) begin
      errors++;
      $display("FAIL rst_held_strobe: %0d strobes, required 1", kv_count - start);
    end
  endtask

  task automatic test_two_keys();
    int start;
    bit saw_row3;
    start = kv_count;
    saw_row3 = 0;
    keys[1] = 1'b1;
    keys[2] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Rows === 4'b0111) saw_row3 = 1;
    end
    keys[1] = 1'b0;
    keys[2] = 1'b0;
    checks++;
    if (kv_count != start || !saw_row3) begin
      errors++;
      $display("FAIL two_keys: strobes=%0d scanning=%b, required 0 1", kv_count - start, saw_row3);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_enter();
    test_held();
    test_bounce();
    test_reset_debounce();
    test_reset_held();
    test_two_keys();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
